// File: rtl/magic_packet_tracker_mc_if.sv
// Bus bundle for magic_packet_tracker_mc: per-channel push/pop strobes and
// capture request in, occupancy / tracking status out.
interface magic_packet_tracker_mc_if #(
  parameter int DEPTH  = 8,
  parameter int NUM_CH = 4,
  parameter int CNTWID = $clog2(DEPTH) + 1,
  parameter int CHWID  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);
  logic [NUM_CH-1:0]        push;
  logic [NUM_CH-1:0]        pop;
  logic                     capture;
  logic [CHWID-1:0]         capture_ch;
  logic [NUM_CH*CNTWID-1:0] occ;
  logic [CNTWID-1:0]        pos;
  logic [CHWID-1:0]         trk_ch;
  logic [1:0]               state;
  logic                     exited;
  logic                     err;

  modport master (
    output push, pop, capture, capture_ch,
    input  occ, pos, trk_ch, state, exited, err
  );

  modport slave (
    input  push, pop, capture, capture_ch,
    output occ, pos, trk_ch, state, exited, err
  );
endinterface

// File: rtl/magic_packet_tracker_mc.sv
// magic_packet_tracker_mc: tracks occupancy of NUM_CH parallel FIFOs and
// follows one captured "magic" packet until it pops out of its channel.
// Optional protocol checking is enabled by defining MPT_ERR_CHECK_EN;
// without it err is tied low.
module magic_packet_tracker_mc #(
  parameter int DEPTH  = 8,
  parameter int NUM_CH = 4,
  parameter int CNTWID = $clog2(DEPTH) + 1,
  parameter int CHWID  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  magic_packet_tracker_mc_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_TRACK = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

  state_e            state_q, state_d;
  logic [CNTWID-1:0] occ_q [NUM_CH];
  logic [CNTWID-1:0] occ_d [NUM_CH];
  logic [CNTWID-1:0] pos_q, pos_d;
  logic [CHWID-1:0]  trk_ch_q, trk_ch_d;
  logic              exited_q, exited_d;

  logic              cap_ok;
  logic              cap_push;
  logic              cap_pop;
  logic [CNTWID-1:0] cap_occ;
  logic              trk_pop;
  logic              valid_cap;

  // Per-channel occupancy update, modulo 2^CNTWID.
  always_comb begin
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      occ_d[i] = occ_q[i] + CNTWID'(bus.push[i]) - CNTWID'(bus.pop[i]);
    end
  end

  // Select strobes of the capture channel and the tracked channel; the
  // compare loop doubles as the capture_ch < NUM_CH range check.
  always_comb begin
    cap_ok   = 1'b0;
    cap_push = 1'b0;
    cap_pop  = 1'b0;
    cap_occ  = '0;
    trk_pop  = 1'b0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (bus.capture_ch == CHWID'(i)) begin
        cap_ok   = 1'b1;
        cap_push = bus.push[i];
        cap_pop  = bus.pop[i];
        cap_occ  = occ_q[i];
      end
      if (trk_ch_q == CHWID'(i)) begin
        trk_pop = bus.pop[i];
      end
    end
  end

  assign valid_cap = bus.capture && (state_q == ST_IDLE) && cap_ok && cap_push;

  // Tracking FSM: next state, magic position and exit pulse.
  always_comb begin
    state_d  = state_q;
    pos_d    = pos_q;
    trk_ch_d = trk_ch_q;
    exited_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (valid_cap) begin
          pos_d    = cap_occ - CNTWID'(cap_pop);
          trk_ch_d = bus.capture_ch;
          state_d  = ST_TRACK;
        end
      end
      ST_TRACK: begin
        if (trk_pop) begin
          if (pos_q != '0) begin
            pos_d = pos_q - CNTWID'(1);
          end else begin
            state_d  = ST_DONE;
            exited_d = 1'b1;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_DONE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      pos_q    <= '0;
      trk_ch_q <= '0;
      exited_q <= 1'b0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        occ_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      pos_q    <= pos_d;
      trk_ch_q <= trk_ch_d;
      exited_q <= exited_d;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        occ_q[i] <= occ_d[i];
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_occ
    assign bus.occ[g*CNTWID +: CNTWID] = occ_q[g];
  end

  assign bus.pos    = pos_q;
  assign bus.trk_ch = trk_ch_q;
  assign bus.state  = state_q;
  assign bus.exited = exited_q;

`ifdef MPT_ERR_CHECK_EN
  logic err_q, err_d;

  // Sticky protocol error: underflow, overflow, or malformed capture in IDLE.
  always_comb begin
    err_d = err_q;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (bus.pop[i] && (occ_q[i] == '0)) begin
        err_d = 1'b1;
      end
      if (bus.push[i] && !bus.pop[i] && (occ_q[i] == CNTWID'(DEPTH))) begin
        err_d = 1'b1;
      end
    end
    if (bus.capture && (state_q == ST_IDLE) && !valid_cap) begin
      err_d = 1'b1;
    end
  end

  // Error flag register.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

endmodule

// File: tb/tb_magic_packet_tracker_mc.sv
// Self-checking bench for magic_packet_tracker_mc. The reference model keeps
// each channel as a queue of packet ids; the magic packet's position is its
// index in that queue. Occupancy is kept as plain modular arithmetic.
module tb_magic_packet_tracker_mc;
  localparam int DEPTH  = 8;
  localparam int NUM_CH = 4;
  localparam int CNTWID = 4;
  localparam int CHWID  = 2;
  localparam int MAGIC  = -1;
`ifdef MPT_ERR_CHECK_EN
  localparam int ERR_ON = 1;
`else
  localparam int ERR_ON = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  magic_packet_tracker_mc_if #(.DEPTH(DEPTH), .NUM_CH(NUM_CH), .CNTWID(CNTWID), .CHWID(CHWID)) bus ();

  magic_packet_tracker_mc #(.DEPTH(DEPTH), .NUM_CH(NUM_CH), .CNTWID(CNTWID), .CHWID(CHWID)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  // Reference model state
  int chq [NUM_CH][$];
  int occ_m [NUM_CH];
  int m_state = 0;
  int m_trk = 0;
  int m_exited = 0;
  int m_err = 0;
  int next_id = 1;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int occ_of(input int ch);
    logic [CNTWID-1:0] v;
    v = bus.occ[ch*CNTWID +: CNTWID];
    return int'(v);
  endfunction

  task automatic model_step();
    int e;
    int ex;
    int valid;
    int v;
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        chq[i].delete();
        occ_m[i] = 0;
      end
      m_state = 0; m_trk = 0; m_exited = 0; m_err = 0;
      return;
    end
    e = 0;
    ex = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (bus.pop[i] && occ_m[i] == 0) e = 1;
      if (bus.push[i] && !bus.pop[i] && occ_m[i] == DEPTH) e = 1;
    end
    valid = (bus.capture && m_state == 0 && int'(bus.capture_ch) < NUM_CH
             && bus.push[bus.capture_ch]) ? 1 : 0;
    if (bus.capture && m_state == 0 && valid == 0) e = 1;
    for (int i = 0; i < NUM_CH; i++) begin
      if (bus.pop[i] && chq[i].size() > 0) begin
        v = chq[i].pop_front();
        if (v == MAGIC && m_state == 1) begin
          m_state = 2;
          ex = 1;
        end
      end
    end
    for (int i = 0; i < NUM_CH; i++) begin
      if (bus.push[i]) begin
        if (valid == 1 && i == int'(bus.capture_ch)) chq[i].push_back(MAGIC);
        else begin
          chq[i].push_back(next_id);
          next_id++;
        end
      end
      occ_m[i] = (occ_m[i] + int'(bus.push[i]) - int'(bus.pop[i])) & ((1 << CNTWID) - 1);
    end
    if (valid == 1) begin
      m_state = 1;
      m_trk = int'(bus.capture_ch);
    end
    m_exited = ex;
    if (ERR_ON == 1 && e == 1) m_err = 1;
  endtask

  task automatic compare_all();
    int ep;
    ep = 0;
    if (m_state == 1) begin
      for (int k = 0; k < chq[m_trk].size(); k++)
        if (chq[m_trk][k] == MAGIC) ep = k;
    end
    for (int i = 0; i < NUM_CH; i++) chk($sformatf("occ[%0d]", i), occ_of(i), occ_m[i]);
    chk("pos", int'(bus.pos), ep);
    chk("trk_ch", int'(bus.trk_ch), m_trk);
    chk("state", int'(bus.state), m_state);
    chk("exited", int'(bus.exited), m_exited);
    chk("err", int'(bus.err), m_err);
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (chk_en) compare_all();
  end

  task automatic cyc(input logic [3:0] pu, input logic [3:0] po, input logic cap, input logic [1:0] ch);
    bus.push = pu;
    bus.pop = po;
    bus.capture = cap;
    bus.capture_ch = ch;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(4'b0000, 4'b0000, 1'b0, 2'd0);
    rst = 1'b0;
    chk_en = 1'b1;
  endtask

  initial begin
    logic [3:0] pu;
    logic [3:0] po;
    logic cap;
    logic [1:0] ch;
    bus.push = '0; bus.pop = '0; bus.capture = 1'b0; bus.capture_ch = '0;
    @(negedge clk);

    // Reset values
    do_reset();
    chk("rst occ", int'(bus.occ), 0);
    chk("rst pos", int'(bus.pos), 0);
    chk("rst state", int'(bus.state), 0);
    chk("rst exited", int'(bus.exited), 0);
    chk("rst err", int'(bus.err), 0);

    // Occupancy
    repeat (3) cyc(4'b0001, 4'b0000, 1'b0, 2'd0);
    repeat (2) cyc(4'b0010, 4'b0010, 1'b0, 2'd0);
    cyc(4'b0000, 4'b0001, 1'b0, 2'd0);
    chk("occ ch0", occ_of(0), 2);
    chk("occ ch1", occ_of(1), 0);
    chk("occ ch2", occ_of(2), 0);
    chk("occ ch3", occ_of(3), 0);
    chk("pushpop-empty err", int'(bus.err), ERR_ON);

    // Capture into ch2 behind three packets
    do_reset();
    repeat (2) cyc(4'b0101, 4'b0000, 1'b0, 2'd0);
    cyc(4'b0100, 4'b0000, 1'b0, 2'd0);
    chk("preload occ ch2", occ_of(2), 3);
    cyc(4'b0100, 4'b0000, 1'b1, 2'd2);
    chk("cap pos", int'(bus.pos), 3);
    chk("cap trk_ch", int'(bus.trk_ch), 2);
    chk("cap state", int'(bus.state), 1);
    chk("cap occ ch2", occ_of(2), 4);

    // Exit sequence
    cyc(4'b0000, 4'b0101, 1'b0, 2'd0);
    chk("exit pos a", int'(bus.pos), 2);
    cyc(4'b0100, 4'b0100, 1'b0, 2'd0);
    chk("exit pos b", int'(bus.pos), 1);
    cyc(4'b0000, 4'b0101, 1'b0, 2'd0);
    chk("exit pos c", int'(bus.pos), 0);
    cyc(4'b0100, 4'b0000, 1'b0, 2'd0);
    chk("exit hold state", int'(bus.state), 1);
    chk("exit hold exited", int'(bus.exited), 0);
    cyc(4'b0000, 4'b0100, 1'b0, 2'd0);
    chk("exit state", int'(bus.state), 2);
    chk("exit pulse", int'(bus.exited), 1);
    cyc(4'b0000, 4'b0000, 1'b0, 2'd0);
    chk("exit pulse end", int'(bus.exited), 0);
    cyc(4'b0010, 4'b0000, 1'b1, 2'd1);
    chk("recap state", int'(bus.state), 2);
    chk("recap trk_ch", int'(bus.trk_ch), 2);
    chk("recap pos", int'(bus.pos), 0);
    chk("recap err", int'(bus.err), 0);

    // Capture-cycle pop on the same channel
    do_reset();
    repeat (2) cyc(4'b0010, 4'b0000, 1'b0, 2'd0);
    cyc(4'b0010, 4'b0010, 1'b1, 2'd1);
    chk("ccpop pos", int'(bus.pos), 1);
    chk("ccpop occ ch1", occ_of(1), 2);
    chk("ccpop state", int'(bus.state), 1);

    // Randomized legal traffic with occasional capture attempts
    for (int r = 0; r < 8; r++) begin
      do_reset();
      for (int n = 0; n < 150; n++) begin
        pu = '0;
        po = '0;
        for (int i = 0; i < NUM_CH; i++) begin
          if (occ_m[i] > 0 && $urandom_range(0, 2) == 0) po[i] = 1'b1;
          if ((occ_m[i] < DEPTH || po[i]) && $urandom_range(0, 1) == 1) pu[i] = 1'b1;
        end
        cap = ($urandom_range(0, 5) == 0);
        ch = 2'($urandom_range(0, 3));
        cyc(pu, po, cap, ch);
      end
    end

    // Protocol errors
    do_reset();
    cyc(4'b0000, 4'b1000, 1'b0, 2'd0);
    chk("underflow err", int'(bus.err), ERR_ON);
    repeat (3) cyc(4'b0000, 4'b0000, 1'b0, 2'd0);
    chk("underflow sticky", int'(bus.err), ERR_ON);
    do_reset();
    chk("err cleared", int'(bus.err), 0);
    cyc(4'b0000, 4'b0000, 1'b1, 2'd0);
    chk("nopush cap err", int'(bus.err), ERR_ON);
    chk("nopush cap state", int'(bus.state), 0);
    repeat (2) cyc(4'b0000, 4'b0000, 1'b0, 2'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/magic_packet_tracker_mc.md
Name: magic_packet_tracker_mc

Overview:
- Multi-channel successor to the single-FIFO magic packet tracker used in the arbitrated-FIFO formal/sim harnesses.
- Tracks occupancy of NUM_CH parallel FIFOs and follows one "magic" packet, captured into any one channel, until it leaves that channel.
- Adds an explicit IDLE/TRACK/DONE state machine, a registered exit pulse, and optional protocol-error checking.
- Sits beside the arbitrated FIFO bank and observes its per-channel push/pop strobes only.

Parameters:
- DEPTH, 8, entries per channel FIFO.
- NUM_CH, 4, number of FIFO channels tracked (>=1).
- CNTWID, $clog2(DEPTH)+1, width of every counter.
- CHWID, (NUM_CH>1 ? $clog2(NUM_CH) : 1), width of the channel index.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- rst  input  1  synchronous active-high reset.
- push  input  NUM_CH  per-channel push strobe, bit i = channel i.
- pop  input  NUM_CH  per-channel pop strobe.
- capture  input  1  the push on channel capture_ch this cycle carries the magic packet.
- capture_ch  input  CHWID  channel being captured into.
- occ  output  NUM_CH*CNTWID  per-channel occupancy; channel i occupies bits [i*CNTWID +: CNTWID].
- pos  output  CNTWID  packets ahead of the magic packet in its channel.
- trk_ch  output  CHWID  channel holding the magic packet.
- state  output  2  00 IDLE, 01 TRACK, 10 DONE; 11 unused.
- exited  output  1  one-cycle registered pulse when the magic packet has popped.
- err  output  1  sticky protocol error (see Optional Feature).

Behaviour:
- Reset: rst is synchronous and active-high, sampled on the rising edge of clk. It has priority over all other inputs on the same edge. Reset values: occ=0 for all channels, pos=0, trk_ch=0, state=IDLE, exited=0, err=0.
- Occupancy, every channel, every state: occ_i_next = occ_i + push[i] - pop[i]. Arithmetic is modulo 2^CNTWID. A simultaneous push and pop leaves occ_i unchanged.
- Valid capture: capture=1 and state=IDLE and capture_ch<NUM_CH and push[capture_ch]=1.
- On a valid capture:
  - pos <= occ[capture_ch] - pop[capture_ch]. The magic packet itself is not counted in pos.
  - trk_ch <= capture_ch.
  - state <= TRACK.
  - occ still counts the magic push.
- Capture in TRACK or DONE is ignored: no change to pos, trk_ch or state.
- Capture with capture_ch>=NUM_CH, or without push[capture_ch], is ignored.
- TRACK:
  - pop[trk_ch]=1 and pos>0: pos <= pos-1.
  - pop[trk_ch]=1 and pos==0: the magic packet leaves. state <= DONE, exited <= 1 for exactly the next cycle, pos holds 0.
  - Pushes on trk_ch never change pos.
  - Pops on other channels do not affect pos.
- DONE: holds until rst. pos and trk_ch are frozen. occ keeps counting.
- exited is 0 in every cycle other than the one following the exit pop.
- Simultaneous capture-cycle pop on the same channel is covered by the pos formula above. With occ=0, this makes pos wrap modulo 2^CNTWID; err flags it when enabled.
- rst in the middle of TRACK returns to IDLE with all counters zeroed on that edge.

Optional Feature:
- Macro: MPT_ERR_CHECK_EN.
- Defined: err is set, and then held until rst, on the edge after any of the following:
  - pop[i] while occ_i==0, for any i.
  - push[i] and not pop[i] while occ_i==DEPTH, for any i.
  - capture=1 that is not a valid capture while state==IDLE.
- Not defined: err is tied to 0 and no checking logic is instantiated. All other behaviour is identical in both builds.

Test Plan:
- Reset then idle, NUM_CH=4: hold rst 1 cycle -> occ=0, pos=0, state=00, exited=0, err=0.
- Occupancy: push ch0 three cycles, push+pop ch1 together two cycles, pop ch0 once -> occ ch0=2, ch1=0, others 0.
- Capture: ch2 preloaded to occ=3, then push+capture with capture_ch=2 -> next cycle pos=3, trk_ch=2, state=TRACK, occ ch2=4.
- Exit: from the previous scenario, pop ch2 four times with interleaved pops on ch0 and pushes on ch2:
  - after each of the first three ch2 pops, pos=2, 1, 0 respectively;
  - the fourth ch2 pop -> state=DONE, with exited=1 for exactly one cycle after it;
  - a second capture afterwards is ignored.
- Capture-cycle pop: ch1 occ=2, push+pop ch1 with capture=1, capture_ch=1 -> pos=1, occ ch1=2.
- Errors, with MPT_ERR_CHECK_EN defined:
  - pop on an empty ch3 -> err=1 the next cycle, stays 1 until rst;
  - capture=1 with no push -> err=1, state stays IDLE;
  - with the macro undefined, the same stimulus gives err=0 throughout.
